// File: rtl/load_extend_unit.sv
// Two-stage elastic load aligner: S1 registers the raw memory request, S2 holds
// the aligned/extended result with its fault flags, plus a saturating fault counter.
module load_extend_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] byte_off,
    input  logic [XLEN-1:0]  mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  Extendido,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("load_extend_unit: XLEN must be 32 or 64");
    end

    logic             s1_v_q, s1_v_d;
    logic [2:0]       s1_f3_q, s1_f3_d;
    logic [OFF_W-1:0] s1_off_q, s1_off_d;
    logic [XLEN-1:0]  s1_data_q, s1_data_d;

    logic             s2_v_q, s2_v_d;
    logic [XLEN-1:0]  s2_ext_q, s2_ext_d;
    logic             s2_mis_q, s2_mis_d;
    logic             s2_ill_q, s2_ill_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             s2_free;
    logic             in_fire;
    logic             s1_move;
    logic             out_fire;

    logic [XLEN-1:0]  field;
    logic [XLEN-1:0]  dec_ext;
    logic             dec_mis;
    logic             dec_ill;

    // Ready depends only on registered state, never on in_valid.
    assign s2_free  = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = s1_v_q && s2_free;
    assign out_fire = s2_v_q && out_ready;

    always_comb begin
        field   = s1_data_q >> {s1_off_q, 3'b000};
        dec_ext = '0;
        dec_mis = 1'b0;
        dec_ill = 1'b0;
        case (s1_f3_q)
            F3_LB: begin
                dec_ext      = {XLEN{field[7]}};
                dec_ext[7:0] = field[7:0];
            end
            F3_LBU: begin
                dec_ext[7:0] = field[7:0];
            end
            F3_LH: begin
                dec_mis       = s1_off_q[0];
                dec_ext       = {XLEN{field[15]}};
                dec_ext[15:0] = field[15:0];
            end
            F3_LHU: begin
                dec_mis       = s1_off_q[0];
                dec_ext[15:0] = field[15:0];
            end
            F3_LW: begin
                dec_mis       = (s1_off_q[1:0] != 2'b00);
                dec_ext       = {XLEN{field[31]}};
                dec_ext[31:0] = field[31:0];
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    dec_mis       = (s1_off_q[1:0] != 2'b00);
                    dec_ext[31:0] = field[31:0];
                end else begin
                    dec_ill = 1'b1;
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    dec_mis = (s1_off_q != '0);
                    dec_ext = field;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        // Faulted results carry no data; illegal masks misaligned.
        if (dec_ill || dec_mis) begin
            dec_ext = '0;
        end
        if (dec_ill) begin
            dec_mis = 1'b0;
        end
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_f3_d   = s1_f3_q;
        s1_off_d  = s1_off_q;
        s1_data_d = s1_data_q;
        if (in_fire) begin
            s1_v_d    = 1'b1;
            s1_f3_d   = funct3;
            s1_off_d  = byte_off;
            s1_data_d = mem_data;
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end

        s2_v_d   = s2_v_q;
        s2_ext_d = s2_ext_q;
        s2_mis_d = s2_mis_q;
        s2_ill_d = s2_ill_q;
        if (s1_move) begin
            s2_v_d   = 1'b1;
            s2_ext_d = dec_ext;
            s2_mis_d = dec_mis;
            s2_ill_d = dec_ill;
        end else if (out_fire) begin
            s2_v_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (out_fire && (s2_mis_q || s2_ill_q) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_f3_q   <= '0;
            s1_off_q  <= '0;
            s1_data_q <= '0;
            s2_v_q    <= 1'b0;
            s2_ext_q  <= '0;
            s2_mis_q  <= 1'b0;
            s2_ill_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_f3_q   <= s1_f3_d;
            s1_off_q  <= s1_off_d;
            s1_data_q <= s1_data_d;
            s2_v_q    <= s2_v_d;
            s2_ext_q  <= s2_ext_d;
            s2_mis_q  <= s2_mis_d;
            s2_ill_q  <= s2_ill_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign Extendido  = s2_ext_q;
    assign misaligned = s2_mis_q;
    assign illegal    = s2_ill_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: XLEN=32/CNT_W=8 and XLEN=64/CNT_W=2 instances,
// checked every cycle against a queue-based reference plus literal expectations.
module tb_load_extend_unit;

    typedef struct {
        logic [63:0] ext;
        bit          mis;
        bit          ill;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inv[2];
    logic        inr[2];
    logic        outv[2];
    logic        ordy[2];
    logic [2:0]  f3s[2];
    logic [2:0]  offs[2];
    logic [63:0] dat[2];
    logic        misw[2];
    logic        illw[2];
    logic [31:0] ext32;
    logic [63:0] ext64;
    logic [7:0]  err32;
    logic [1:0]  err64;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   errm[2];
    int   popped[2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    load_extend_unit #(.XLEN(32), .CNT_W(8)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(inv[0]), .in_ready(inr[0]),
        .funct3(f3s[0]), .byte_off(offs[0][1:0]), .mem_data(dat[0][31:0]),
        .out_valid(outv[0]), .out_ready(ordy[0]),
        .Extendido(ext32), .misaligned(misw[0]), .illegal(illw[0]),
        .err_cnt(err32)
    );

    load_extend_unit #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(inv[1]), .in_ready(inr[1]),
        .funct3(f3s[1]), .byte_off(offs[1]), .mem_data(dat[1]),
        .out_valid(outv[1]), .out_ready(ordy[1]),
        .Extendido(ext64), .misaligned(misw[1]), .illegal(illw[1]),
        .err_cnt(err64)
    );

    function automatic logic [63:0] ext_of(input int d);
        return (d == 0) ? {32'd0, ext32} : ext64;
    endfunction

    function automatic logic [7:0] err_of(input int d);
        return (d == 0) ? err32 : {6'd0, err64};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V load semantics in plain arithmetic on the shifted word.
    function automatic exp_t model(input int xl, input logic [2:0] f3, input logic [2:0] off,
                                   input logic [63:0] data);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] fld;
        logic [63:0] v;
        mask  = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        fld   = (data & mask) >> (64'(off) * 64'd8);
        e.ill = (f3 == 3'b111) || (xl == 32 && (f3 == 3'b011 || f3 == 3'b110));
        case (f3[1:0])
            2'd0:    e.mis = 1'b0;
            2'd1:    e.mis = (off % 3'd2) != 3'd0;
            2'd2:    e.mis = (off % 3'd4) != 3'd0;
            default: e.mis = off != 3'd0;
        endcase
        case (f3)
            3'b000: begin
                v = fld % 64'd256;
                if (v >= 64'd128) v = v - 64'd256;
            end
            3'b100: v = fld % 64'd256;
            3'b001: begin
                v = fld % 64'd65536;
                if (v >= 64'd32768) v = v - 64'd65536;
            end
            3'b101: v = fld % 64'd65536;
            3'b010: begin
                v = fld % 64'h1_0000_0000;
                if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
            end
            3'b110:  v = fld % 64'h1_0000_0000;
            default: v = fld;
        endcase
        if (e.ill) begin
            e.mis = 1'b0;
            v     = 64'd0;
        end else if (e.mis) begin
            v = 64'd0;
        end
        e.ext = v & mask;
        e.acc = 0;
        return e;
    endfunction

    task automatic compare_dut(input int d);
        exp_t  fr;
        int    n;
        int    emax;
        logic  ov_exp;
        string tag;
        tag  = (d == 0) ? "x32" : "x64";
        emax = (d == 0) ? 255 : 3;
        fr   = '{ext: 64'd0, mis: 1'b0, ill: 1'b0, acc: 0};
        if (d == 0) begin
            n = q0.size();
            if (n > 0) fr = q0[0];
        end else begin
            n = q1.size();
            if (n > 0) fr = q1[0];
        end
        if (rst) begin
            chk({tag, ".rst_out_valid"}, 64'(outv[d]), 64'd0);
            chk({tag, ".rst_ext"}, ext_of(d), 64'd0);
            chk({tag, ".rst_mis"}, 64'(misw[d]), 64'd0);
            chk({tag, ".rst_ill"}, 64'(illw[d]), 64'd0);
            chk({tag, ".rst_err_cnt"}, 64'(err_of(d)), 64'd0);
            if (d == 0) q0.delete(); else q1.delete();
            errm[d] = 0;
            return;
        end
        chk({tag, ".in_ready"}, 64'(inr[d]), 64'((n < 2) || ordy[d]));
        ov_exp = (n > 0) && (cyc >= fr.acc + 2);
        chk({tag, ".out_valid"}, 64'(outv[d]), 64'(ov_exp));
        if (outv[d] && n > 0) begin
            chk({tag, ".ext"}, ext_of(d), fr.ext);
            chk({tag, ".mis"}, 64'(misw[d]), 64'(fr.mis));
            chk({tag, ".ill"}, 64'(illw[d]), 64'(fr.ill));
        end
        chk({tag, ".err_cnt"}, 64'(err_of(d)), 64'(errm[d]));
        if (outv[d] && ordy[d] && n > 0) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            popped[d]++;
            if (fr.mis || fr.ill) errm[d] = (errm[d] >= emax) ? emax : errm[d] + 1;
        end
        if (inv[d] && inr[d]) begin
            fr     = model((d == 0) ? 32 : 64, f3s[d], offs[d], dat[d]);
            fr.acc = cyc;
            if (d == 0) q0.push_back(fr); else q1.push_back(fr);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cyc++;
            compare_dut(0);
            compare_dut(1);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] data);
        int t = 0;
        inv[d]  = 1'b1;
        f3s[d]  = f3;
        offs[d] = off;
        dat[d]  = data;
        @(negedge clk);
        while (!inr[d]) begin
            t++;
            if (t > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready stuck at 0 for d=%0d", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        inv[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input string nm, input logic [63:0] e_ext,
                            input logic e_mis, input logic e_ill);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!outv[d] && t < 10);
        chk({nm, ".latency"}, 64'(t), 64'd2);
        chk({nm, ".ext"}, ext_of(d), e_ext);
        chk({nm, ".mis"}, 64'(misw[d]), 64'(e_mis));
        chk({nm, ".ill"}, 64'(illw[d]), 64'(e_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t m;
        int   p0;
        int   stale;
        for (int d = 0; d < 2; d++) begin
            inv[d]    = 1'b0;
            ordy[d]   = 1'b1;
            f3s[d]    = 3'd0;
            offs[d]   = 3'd0;
            dat[d]    = 64'd0;
            errm[d]   = 0;
            popped[d] = 0;
        end
        fork
            compare_loop();
        join_none

        m = model(32, 3'b000, 3'd0, 64'h0000_00FA);
        chk("model.lb", m.ext, 64'h0000_0000_FFFF_FFFA);
        m = model(32, 3'b001, 3'd2, 64'h8001_1234);
        chk("model.lh", m.ext, 64'h0000_0000_FFFF_8001);
        m = model(64, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000);
        chk("model.lwu", m.ext, 64'h0000_0000_DEAD_BEEF);
        m = model(64, 3'b010, 3'd4, 64'hDEAD_BEEF_0000_0000);
        chk("model.lw64", m.ext, 64'hFFFF_FFFF_DEAD_BEEF);
        m = model(32, 3'b001, 3'd1, 64'h8001_1234);
        chk("model.lh_mis", 64'(m.mis), 64'd1);
        m = model(32, 3'b011, 3'd1, 64'h1);
        chk("model.ld32_ill", 64'({m.ill, m.mis}), 64'd2);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("x32.post_rst_in_ready", 64'(inr[0]), 64'd1);
        chk("x64.post_rst_in_ready", 64'(inr[1]), 64'd1);
        @(posedge clk);
        #1;

        send(0, 3'b000, 3'd0, 64'h0000_00FA);
        wait_out(0, "lb", 64'hFFFF_FFFA, 1'b0, 1'b0);
        send(0, 3'b100, 3'd0, 64'h0000_00FA);
        wait_out(0, "lbu", 64'h0000_00FA, 1'b0, 1'b0);
        send(0, 3'b001, 3'd2, 64'h8001_1234);
        wait_out(0, "lh", 64'hFFFF_8001, 1'b0, 1'b0);
        send(0, 3'b101, 3'd2, 64'h8001_1234);
        wait_out(0, "lhu", 64'h0000_8001, 1'b0, 1'b0);
        send(0, 3'b001, 3'd1, 64'h8001_1234);
        wait_out(0, "lh_mis", 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("err_after_mis", 64'(err32), 64'd1);
        @(posedge clk);
        #1;
        send(0, 3'b111, 3'd1, 64'h8001_1234);
        wait_out(0, "f3_111", 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_after_ill", 64'(err32), 64'd2);
        @(posedge clk);
        #1;
        send(0, 3'b010, 3'd0, 64'h8000_0001);
        wait_out(0, "lw32", 64'h8000_0001, 1'b0, 1'b0);
        send(0, 3'b010, 3'd2, 64'h8000_0001);
        wait_out(0, "lw32_mis", 64'h0, 1'b1, 1'b0);
        send(0, 3'b011, 3'd1, 64'h8000_0001);
        wait_out(0, "ld32_ill", 64'h0, 1'b0, 1'b1);
        send(0, 3'b000, 3'd3, 64'h7F00_0000);
        wait_out(0, "lb_off3", 64'h0000_007F, 1'b0, 1'b0);
        send(0, 3'b000, 3'd1, 64'h0000_9C00);
        wait_out(0, "lb_off1", 64'hFFFF_FF9C, 1'b0, 1'b0);
        send(0, 3'b100, 3'd3, 64'h80FF_FFFF);
        wait_out(0, "lbu_off3", 64'h0000_0080, 1'b0, 1'b0);

        // Four back-to-back requests into a stalled consumer.
        p0      = popped[0];
        ordy[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 3'b100, 3'(i), 64'h4433_2281);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(inr[0]), 64'd0);
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("stall_delivered", 64'(popped[0] - p0), 64'd4);
        chk("stall_drained", 64'(q0.size()), 64'd0);

        // Reset with both stages occupied.
        ordy[0] = 1'b0;
        send(0, 3'b100, 3'd0, 64'h0000_00AB);
        send(0, 3'b001, 3'd0, 64'h0000_1234);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(outv[0]), 64'd0);
        chk("rst_mid_err_cnt", 64'(err32), 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ordy[0] = 1'b1;
        stale   = 0;
        repeat (6) begin
            @(negedge clk);
            if (outv[0]) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;

        send(1, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000);
        wait_out(1, "lwu64", 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        send(1, 3'b010, 3'd4, 64'hDEAD_BEEF_0000_0000);
        wait_out(1, "lw64", 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1'b0);
        send(1, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF);
        wait_out(1, "ld64", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        send(1, 3'b001, 3'd6, 64'hBEEF_0000_0000_0000);
        wait_out(1, "lh64_off6", 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 1'b0);
        send(1, 3'b100, 3'd7, 64'h9A00_0000_0000_0000);
        wait_out(1, "lbu64_off7", 64'h0000_0000_0000_009A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(1, 3'b111, 3'(i), 64'h1111_2222_3333_4444);
        repeat (4) @(negedge clk);
        chk("err64_saturate", 64'(err64), 64'd3);
        @(posedge clk);
        #1;
        send(1, 3'b011, 3'd4, 64'h0123_4567_89AB_CDEF);
        wait_out(1, "ld64_mis", 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("err64_hold", 64'(err64), 64'd3);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
